// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle control FSM for an RV32I core (ALU-interface initiator).
// Sequences IF/ID/EX/MEM/WB and handshakes a variable-latency memory through mem_ready.
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   opcode, funct3, funct7_5            instruction fields held in the IR
//   halt_cond, alu_bcond, mem_ready     datapath/ALU/memory status inputs
//   alu_op, btype, alu_src_a, alu_src_b ALU control
//   pc_write, pc_source, i_or_d         PC and memory address control
//   mem_read, mem_write, ir_write       memory and IR control
//   reg_write, wb_sel                   register file writeback control
//   halted, illegal                     core status
// Optional: define MC_CTRL_PERF_EN to add cycle_cnt and instret_cnt (PERF_W bits wide).
module mc_control_unit #(
    parameter bit HALT_ON_ILLEGAL = 1'b1,
    parameter int PERF_W          = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       halt_cond,
    input  logic       alu_bcond,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic [1:0] btype,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_write,
    output logic       pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] wb_sel,
    output logic       halted,
    output logic       illegal
`ifdef MC_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] instret_cnt
`endif
);
    localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_SYS = 7'b1110011;
    localparam logic [3:0] ADD = 4'b0000, SUB = 4'b0001, AND = 4'b0100, OR = 4'b0101;
    localparam logic [3:0] XOR = 4'b1000, SLL = 4'b1010, SRL = 4'b1011, SRA = 4'b1101;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;
    state_t state, next;

    logic is_r, is_i, is_ld, is_st, is_br, is_sys, known;
    logic [3:0] arith_op;

    assign is_r   = opcode == OP_R;
    assign is_i   = opcode == OP_I;
    assign is_ld  = opcode == OP_LD;
    assign is_st  = opcode == OP_ST;
    assign is_br  = opcode == OP_BR;
    assign is_sys = opcode == OP_SYS;
    assign known  = is_r || is_i || is_ld || is_st || is_br || is_sys || opcode == OP_LUI ||
                    opcode == OP_AUIPC || opcode == OP_JAL || opcode == OP_JALR;
    assign halted = state == S_HALT;

    // funct7_5 selects SUB only for R-type; it selects SRA for both R and I shifts.
    always_comb begin
        case (funct3)
            3'b000:  arith_op = (is_r && funct7_5) ? SUB : ADD;
            3'b001:  arith_op = SLL;
            3'b100:  arith_op = XOR;
            3'b101:  arith_op = funct7_5 ? SRA : SRL;
            3'b110:  arith_op = OR;
            3'b111:  arith_op = AND;
            default: arith_op = ADD;
        endcase
    end

    // Everything is forced low while reset_n is low, even though state already sits in S_IF.
    always_comb begin
        next      = state;
        alu_op    = ADD;
        btype     = 2'd0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        pc_write  = 1'b0;
        pc_source = 1'b0;
        i_or_d    = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        if (reset_n) begin
            case (state)
                S_IF: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'd1;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                    next      = mem_ready ? S_ID : S_IF;
                end
                S_ID: begin
                    alu_src_a = 2'd2;
                    alu_src_b = 2'd2;
                    next = is_sys ? (halt_cond ? S_HALT : S_IF) :
                           !known ? (HALT_ON_ILLEGAL ? S_HALT : S_IF) : S_EX;
                end
                S_EX: begin
                    next = S_WB;
                    if (is_r) begin
                        alu_src_a = 2'd1;
                        alu_op    = arith_op;
                    end else if (is_i) begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        alu_op    = arith_op;
                    end else if (opcode == OP_LUI) begin
                        alu_src_a = 2'd3;
                        alu_src_b = 2'd2;
                    end else if (opcode == OP_AUIPC) begin
                        alu_src_a = 2'd2;
                        alu_src_b = 2'd2;
                    end else if (is_ld || is_st) begin
                        alu_src_a = 2'd1;
                        alu_src_b = 2'd2;
                        next      = S_MEM;
                    end else if (is_br) begin
                        alu_src_a = 2'd1;
                        alu_op    = SUB;
                        btype     = {funct3[2], funct3[0]};
                        pc_write  = alu_bcond;
                        pc_source = 1'b1;
                        next      = S_IF;
                    end else begin
                        // JAL takes the target ALUOut computed in ID; JALR takes the live ALU sum.
                        alu_src_a = (opcode == OP_JALR) ? 2'd1 : 2'd0;
                        alu_src_b = (opcode == OP_JALR) ? 2'd2 : 2'd0;
                        pc_source = opcode == OP_JAL;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = 2'd2;
                        next      = S_IF;
                    end
                end
                S_MEM: begin
                    i_or_d    = 1'b1;
                    mem_read  = is_ld;
                    mem_write = !is_ld;
                    next      = !mem_ready ? S_MEM : is_ld ? S_WB : S_IF;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    wb_sel    = is_ld ? 2'd1 : 2'd0;
                    next      = S_IF;
                end
                default: next = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IF;
            illegal <= 1'b0;
`ifdef MC_CTRL_PERF_EN
            cycle_cnt   <= '0;
            instret_cnt <= '0;
`endif
        end else begin
            state <= next;
            if (state == S_ID && !known && HALT_ON_ILLEGAL)
                illegal <= 1'b1;
`ifdef MC_CTRL_PERF_EN
            if (state != S_HALT)
                cycle_cnt <= cycle_cnt + 1'b1;
            // A NOP ECALL is an ID->IF transition, so it is counted here too.
            if (state != S_IF && next == S_IF)
                instret_cnt <= instret_cnt + 1'b1;
`endif
        end
    end

`ifndef MC_CTRL_PERF_EN
    // PERF_W only sizes the counters; keep it referenced when they are compiled out.
    localparam int unused_perf_w = PERF_W;
`endif
endmodule
